// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and stall control for a 5-stage in-order pipeline. Tracks the
// control fields of the ID/EX, EX/MEM and MEM/WB slots, detects memory-wait,
// taken-branch and load-use hazards, and drives the PC / IF/ID enables.
// Forwarding-relevant slot fields are exported directly from the registers.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rs2,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic        ex_mem_regwrite,
    output logic [4:0]  ex_mem_rd,
    output logic        mem_wb_regwrite,
    output logic [4:0]  mem_wb_rd,
    output logic        ex_mem_memread,
    output logic        ex_mem_memwrite,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);

    // Control fields carried by every pipeline slot.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } slot_t;

    // Stall cause; the encoding is the externally visible state code.
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10,
        FLUSH      = 2'b11
    } cause_e;

    localparam slot_t BUBBLE = '0;

    slot_t       id_ex_q, id_ex_d;
    slot_t       ex_mem_q, ex_mem_d;
    slot_t       mem_wb_q, mem_wb_d;
    slot_t       id_slot;
    cause_e      state_q, cause_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        mem_wait;
    logic        load_use;
    logic        rd_hits_rs1;
    logic        rd_hits_rs2;

    // Pack the decoded instruction into slot form.
    assign id_slot = '{valid:    id_valid,
                       rs1:      id_rs1,
                       rs2:      id_rs2,
                       rd:       id_rd,
                       regwrite: id_regwrite,
                       memread:  id_memread,
                       memwrite: id_memwrite};

    // Hazard detection and priority resolution of the active stall cause.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mem_wait    = ex_mem_q.valid && (ex_mem_q.memread || ex_mem_q.memwrite)
                      && !mem_ready;
        // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
        rd_hits_rs1 = (id_ex_q.rd == id_rs1);
        rd_hits_rs2 = id_uses_rs2 && (id_ex_q.rd == id_rs2);
        load_use    = id_valid && id_ex_q.valid && id_ex_q.memread
                      && (id_ex_q.rd != 5'd0) && (rd_hits_rs1 || rd_hits_rs2);

        cause_d = RUN;
        if (mem_wait) begin
            cause_d = MEM_WAIT;
        end else if (branch_taken) begin
            cause_d = FLUSH;
        end else if (load_use) begin
            cause_d = LOAD_STALL;
        end
    end

    // Front-end enables and next slot contents for the resolved cause.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_d     = id_slot;
        ex_mem_d    = id_ex_q;
        mem_wb_d    = ex_mem_q;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
        end else begin
            unique case (cause_d)
                MEM_WAIT: begin
                    // Freeze everything upstream of MEM; only WB drains.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_d     = id_ex_q;
                    ex_mem_d    = ex_mem_q;
                    mem_wb_d    = BUBBLE;
                end
                FLUSH: begin
                    // The IF/ID register is written with a bubble on a flush.
                    if_id_flush = 1'b1;
                    id_ex_d     = BUBBLE;
                end
                LOAD_STALL: begin
                    // Hold the consumer in ID while the load moves on to MEM.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_d     = BUBBLE;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of cycles lost to any stall or flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((cause_d != RUN) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Slot registers, cause register and stall counter with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            id_ex_q     <= BUBBLE;
            ex_mem_q    <= BUBBLE;
            mem_wb_q    <= BUBBLE;
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            id_ex_q     <= id_ex_d;
            ex_mem_q    <= ex_mem_d;
            mem_wb_q    <= mem_wb_d;
            state_q     <= cause_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Forwarding and status outputs come straight from the registers.
    assign id_ex_rs1       = id_ex_q.rs1;
    assign id_ex_rs2       = id_ex_q.rs2;
    assign ex_mem_regwrite = ex_mem_q.valid & ex_mem_q.regwrite;
    assign ex_mem_rd       = ex_mem_q.rd;
    assign mem_wb_regwrite = mem_wb_q.valid & mem_wb_q.regwrite;
    assign mem_wb_rd       = mem_wb_q.rd;
    assign ex_mem_memread  = ex_mem_q.memread;
    assign ex_mem_memwrite = ex_mem_q.memwrite;
    assign state           = state_q;
    assign stall_cycles    = stall_cnt_q;

    // Slot fields kept for completeness but not consumed downstream here.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{ex_mem_q.rs1, ex_mem_q.rs2,
                                mem_wb_q.rs1, mem_wb_q.rs2,
                                mem_wb_q.memread, mem_wb_q.memwrite};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench: a slot-list model of the pipeline is stepped each
// cycle and every DUT output is compared against it; directed scenarios add
// literal expectations, then randomized traffic runs against the model.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs2, id_regwrite, id_memread, id_memwrite;
    logic        branch_taken, mem_ready;
    logic        pc_write, if_id_write, if_id_flush;
    logic [4:0]  id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
    logic        ex_mem_regwrite, mem_wb_regwrite, ex_mem_memread, ex_mem_memwrite;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
    slot_t       pipe [3];
    logic [1:0]  m_state;
    logic [15:0] m_cnt;
    bit          m_known = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs2(id_uses_rs2), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
        .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic slot_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input logic rw, input logic ld,
                                 input logic st);
        slot_t s;
        s = '{valid: v, rs1: r1, rs2: r2, rd: rd, regwrite: rw, memread: ld, memwrite: st};
        return s;
    endfunction

    // Cause code from the hazard rules applied to the model and current inputs.
    function automatic logic [1:0] model_cause();
        bit mw, lu;
        mw = pipe[1].valid && (pipe[1].memread || pipe[1].memwrite) && !mem_ready;
        lu = id_valid && pipe[0].valid && pipe[0].memread && (pipe[0].rd != 0)
             && ((pipe[0].rd == id_rs1) || (id_uses_rs2 && (pipe[0].rd == id_rs2)));
        if (mw) return 2'd2;
        if (branch_taken) return 2'd3;
        if (lu) return 2'd1;
        return 2'd0;
    endfunction

    // Drive one cycle of inputs at the falling edge, then compare all outputs.
    task automatic drive(input logic rst, input slot_t id, input logic uses,
                         input logic br, input logic mr);
        logic [1:0] c;
        @(negedge clk);
        reset        = rst;
        id_valid     = id.valid;
        id_rs1       = id.rs1;
        id_rs2       = id.rs2;
        id_rd        = id.rd;
        id_regwrite  = id.regwrite;
        id_memread   = id.memread;
        id_memwrite  = id.memwrite;
        id_uses_rs2  = uses;
        branch_taken = br;
        mem_ready    = mr;
        #1;
        c = model_cause();
        if (rst) begin
            check("pc_write", {15'd0, pc_write}, 16'd0);
            check("if_id_write", {15'd0, if_id_write}, 16'd0);
            check("if_id_flush", {15'd0, if_id_flush}, 16'd1);
        end else begin
            check("pc_write", {15'd0, pc_write}, {15'd0, (c == 2'd0) || (c == 2'd3)});
            check("if_id_flush", {15'd0, if_id_flush}, {15'd0, c == 2'd3});
            if (c != 2'd3)
                check("if_id_write", {15'd0, if_id_write}, {15'd0, c == 2'd0});
        end
        if (m_known) begin
            check("id_ex_rs1", {11'd0, id_ex_rs1}, {11'd0, pipe[0].rs1});
            check("id_ex_rs2", {11'd0, id_ex_rs2}, {11'd0, pipe[0].rs2});
            check("ex_mem_regwrite", {15'd0, ex_mem_regwrite},
                  {15'd0, pipe[1].valid & pipe[1].regwrite});
            check("ex_mem_rd", {11'd0, ex_mem_rd}, {11'd0, pipe[1].rd});
            check("ex_mem_memread", {15'd0, ex_mem_memread}, {15'd0, pipe[1].memread});
            check("ex_mem_memwrite", {15'd0, ex_mem_memwrite}, {15'd0, pipe[1].memwrite});
            check("mem_wb_regwrite", {15'd0, mem_wb_regwrite},
                  {15'd0, pipe[2].valid & pipe[2].regwrite});
            check("mem_wb_rd", {11'd0, mem_wb_rd}, {11'd0, pipe[2].rd});
            check("state", {14'd0, state}, {14'd0, m_state});
            check("stall_cycles", stall_cycles, m_cnt);
        end
    endtask

    // Advance the model across the rising edge; returns 1 time unit later.
    task automatic step();
        logic [1:0] c;
        logic       rst;
        slot_t      id;
        c   = model_cause();
        rst = reset;
        id  = mk(id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memwrite);
        @(posedge clk);
        if (rst) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
            m_state = 2'd0;
            m_cnt   = 16'd0;
            m_known = 1;
        end else begin
            case (c)
                2'd2: pipe[2] = '0;
                2'd0: begin
                    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = id;
                end
                default: begin
                    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = '0;
                end
            endcase
            m_state = c;
            if ((c != 2'd0) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    task automatic cycle(input logic rst, input slot_t id, input logic uses,
                         input logic br, input logic mr);
        drive(rst, id, uses, br, mr);
        step();
    endtask

    task automatic do_reset();
        cycle(1'b1, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, '0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic slot_t rand_id();
        slot_t s;
        int k;
        s.valid    = ($urandom_range(0, 7) != 0);
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.rd       = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 3));
        s.regwrite = $urandom_range(0, 1) == 1;
        k          = $urandom_range(0, 5);
        s.memread  = (k <= 1);
        s.memwrite = (k == 2);
        return s;
    endfunction

    slot_t nop;

    initial begin
        nop = '0;

        // Reset: outputs cleared, front end flushed.
        do_reset();
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_cnt", stall_cycles, 16'd0);
        check("rst_ex_mem_rw", {15'd0, ex_mem_regwrite}, 16'd0);

        // Forwarding pipeline latency for a regwrite to x7.
        cycle(1'b0, mk(1, 5'd1, 5'd2, 5'd7, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, nop, 1'b0, 1'b0, 1'b1);
        check("fwd_ex_mem_rd", {11'd0, ex_mem_rd}, 16'd7);
        check("fwd_ex_mem_rw", {15'd0, ex_mem_regwrite}, 16'd1);
        cycle(1'b0, nop, 1'b0, 1'b0, 1'b1);
        check("fwd_mem_wb_rd", {11'd0, mem_wb_rd}, 16'd7);
        check("fwd_mem_wb_rw", {15'd0, mem_wb_regwrite}, 16'd1);

        // Load-use on x5.
        do_reset();
        cycle(1'b0, mk(1, 5'd1, 5'd0, 5'd5, 1, 1, 0), 1'b0, 1'b0, 1'b1);
        drive(1'b0, mk(1, 5'd5, 5'd0, 5'd6, 1, 0, 0), 1'b0, 1'b0, 1'b1);
        check("lu_pc_write", {15'd0, pc_write}, 16'd0);
        check("lu_if_id_write", {15'd0, if_id_write}, 16'd0);
        step();
        check("lu_state", {14'd0, state}, 16'd1);
        check("lu_cnt", stall_cycles, 16'd1);
        check("lu_bubble_rs1", {11'd0, id_ex_rs1}, 16'd0);
        check("lu_load_adv", {11'd0, ex_mem_rd}, 16'd5);
        cycle(1'b0, mk(1, 5'd5, 5'd0, 5'd6, 1, 0, 0), 1'b0, 1'b0, 1'b1);
        check("lu_resume_state", {14'd0, state}, 16'd0);

        // Load to x0 never stalls.
        do_reset();
        cycle(1'b0, mk(1, 5'd3, 5'd0, 5'd0, 1, 1, 0), 1'b0, 1'b0, 1'b1);
        drive(1'b0, mk(1, 5'd0, 5'd0, 5'd4, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        check("x0_pc_write", {15'd0, pc_write}, 16'd1);
        step();
        check("x0_state", {14'd0, state}, 16'd0);

        // Store waits three cycles on memory.
        do_reset();
        cycle(1'b0, mk(1, 5'd2, 5'd3, 5'd0, 0, 0, 1), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, mk(1, 5'd4, 5'd0, 5'd9, 1, 0, 0), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, mk(1, 5'd11, 5'd0, 5'd10, 1, 0, 0), 1'b0, 1'b0, 1'b0);
            check("mw_pc_write", {15'd0, pc_write}, 16'd0);
            step();
            check("mw_state", {14'd0, state}, 16'd2);
            check("mw_hold_ex_mem", {15'd0, ex_mem_memwrite}, 16'd1);
            check("mw_hold_id_ex", {11'd0, id_ex_rs1}, 16'd4);
            check("mw_wb_bubble", {15'd0, mem_wb_regwrite}, 16'd0);
        end
        check("mw_cnt", stall_cycles, 16'd3);
        drive(1'b0, mk(1, 5'd11, 5'd0, 5'd10, 1, 0, 0), 1'b0, 1'b0, 1'b1);
        check("mw_resume_pc", {15'd0, pc_write}, 16'd1);
        step();
        check("mw_resume_state", {14'd0, state}, 16'd0);
        check("mw_resume_ex_mem_rd", {11'd0, ex_mem_rd}, 16'd9);

        // Branch beats load-use; memory wait beats branch.
        do_reset();
        cycle(1'b0, mk(1, 5'd1, 5'd0, 5'd5, 1, 1, 0), 1'b0, 1'b0, 1'b1);
        drive(1'b0, mk(1, 5'd5, 5'd0, 5'd6, 1, 0, 0), 1'b0, 1'b1, 1'b1);
        check("br_flush", {15'd0, if_id_flush}, 16'd1);
        check("br_pc_write", {15'd0, pc_write}, 16'd1);
        step();
        check("br_state", {14'd0, state}, 16'd3);
        drive(1'b0, mk(1, 5'd5, 5'd0, 5'd6, 1, 0, 0), 1'b0, 1'b1, 1'b0);
        check("br_mw_flush", {15'd0, if_id_flush}, 16'd0);
        check("br_mw_pc_write", {15'd0, pc_write}, 16'd0);
        step();
        check("br_mw_state", {14'd0, state}, 16'd2);
        check("br_mw_cnt", stall_cycles, 16'd2);

        // Reset in the middle of a memory wait.
        do_reset();
        cycle(1'b0, mk(1, 5'd2, 5'd0, 5'd8, 1, 1, 0), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, mk(1, 5'd3, 5'd0, 5'd9, 1, 0, 0), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, nop, 1'b0, 1'b0, 1'b0);
        drive(1'b1, nop, 1'b0, 1'b0, 1'b0);
        check("rmw_flush", {15'd0, if_id_flush}, 16'd1);
        step();
        check("rmw_state", {14'd0, state}, 16'd0);
        check("rmw_cnt", stall_cycles, 16'd0);
        check("rmw_ex_mem_rw", {15'd0, ex_mem_regwrite}, 16'd0);
        check("rmw_mem_wb_rw", {15'd0, mem_wb_regwrite}, 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 99) == 0, rand_id(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
